// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle and has a fixed latency for every input.
// While an operation is in flight it stalls execute through insert_bubble.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       div_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             insert_bubble
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    counter;
   logic             is_rem;
   logic             neg_q;
   logic             neg_r;
   logic             dz;
   logic             ovf;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] dvd_orig;

   logic             sgn_in;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] min_neg;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // Operand magnitudes at acceptance and the shift/trial-subtract step of CALC
   always_comb begin
      sgn_in  = ~div_op[0];
      min_neg = {1'b1, {(WIDTH-1){1'b0}}};
      dvd_mag = (sgn_in & dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
      dvs_mag = (sgn_in & divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
      rem_sh  = {rem, quo[WIDTH-1]};
      diff    = rem_sh - {1'b0, dvs};
   end

   // Stall execute from acceptance through FIX; never while reset is active
   assign insert_bubble = ~rst & (((state == IDLE) & start & ~flush) |
                                  (state == CALC) | (state == FIX));

   // Divider FSM with registered result and done
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         counter  <= '0;
         is_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
         ovf      <= 1'b0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         dvd_orig <= '0;
         result   <= '0;
         done     <= 1'b0;
      end else if (flush) begin
         state   <= IDLE;
         counter <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_rem   <= div_op[1];
                  quo      <= dvd_mag;
                  dvs      <= dvs_mag;
                  dvd_orig <= dividend;
                  neg_q    <= sgn_in & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & (divisor != '0);
                  neg_r    <= sgn_in & dividend[WIDTH-1];
                  dz       <= (divisor == '0);
                  ovf      <= sgn_in & (dividend == min_neg) & (divisor == '1);
                  rem      <= '0;
                  counter  <= '0;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               counter <= counter + 1'b1;
               if (counter == LAST) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (dz) begin
                  result <= is_rem ? dvd_orig : '1;
               end else if (ovf) begin
                  result <= is_rem ? '0 : min_neg;
               end else if (is_rem) begin
                  result <= neg_r ? (~rem + 1'b1) : rem;
               end else begin
                  result <= neg_q ? (~quo + 1'b1) : quo;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: the driver pushes expected results and
// their completion cycle, and a monitor pops and compares on every done pulse.
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   div_op = 2'b00;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] result;
   logic         done;
   logic         insert_bubble;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_res_q[$];
   int           exp_cyc_q[$];
   string        exp_name_q[$];

   div_unit #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .flush         (flush),
      .div_op        (div_op),
      .dividend      (dividend),
      .divisor       (divisor),
      .result        (result),
      .done          (done),
      .insert_bubble (insert_bubble)
   );

   // Free-running clock and cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_done: got done=1 at cycle %0d expected no pending result", cyc);
         end else begin
            automatic logic [W-1:0] er = exp_res_q.pop_front();
            automatic int           ec = exp_cyc_q.pop_front();
            automatic string        en = exp_name_q.pop_front();
            checkOutput(en, result, er);
            checkOutput({en, "_latency"}, W'(cyc), W'(ec));
         end
      end
   end

   // Issue one operation in cycle k and check the bubble window k..k+34
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp, input string name, input bit hold);
      int k;
      int bad;
      @(negedge clk);
      div_op   = op;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      #1;
      k = cyc;
      exp_res_q.push_back(exp);
      exp_cyc_q.push_back(k + W + 2);
      exp_name_q.push_back(name);
      bad = (insert_bubble !== 1'b1) ? 1 : 0;
      for (int i = 1; i <= W + 2; i++) begin
         @(negedge clk);
         if (i == 1 && !hold) begin
            start    = 1'b0;
            dividend = ~a;
            divisor  = a ^ b;
            div_op   = ~op;
         end
         #1;
         if (insert_bubble !== ((i <= W + 1) ? 1'b1 : 1'b0)) bad++;
      end
      checkOutput({name, "_bubble"}, W'(bad), '0);
   endtask

   // Abort an operation at k+10 with rst or flush and check the quiet state at k+11
   task automatic abortTest(input bit use_rst);
      @(negedge clk);
      div_op   = 2'b01;
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      if (use_rst) rst = 1'b1;
      else         flush = 1'b1;
      #1;
      if (use_rst) checkOutput("rst_bubble_during", W'(insert_bubble), '0);
      @(negedge clk);
      rst   = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput(use_rst ? "rst_done" : "flush_done", W'(done), '0);
      checkOutput(use_rst ? "rst_bubble" : "flush_bubble", W'(insert_bubble), '0);
      if (use_rst) checkOutput("rst_result", result, '0);
   endtask

   // Hard time limit so the bench always terminates
   initial begin
      #500000;
      $display("[TB] FAIL timeout: got no finish expected finish before 500000");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus sequence
   initial begin
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_result", result, '0);
      checkOutput("reset_done", W'(done), '0);
      checkOutput("reset_bubble", W'(insert_bubble), '0);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;

      applyStimulus(2'b01, 32'd100,      32'd7,          32'd14,         "divu_100_7", 1'b0);
      applyStimulus(2'b11, 32'd100,      32'd7,          32'd2,          "remu_100_7", 1'b0);
      applyStimulus(2'b00, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   "div_m100_7", 1'b0);
      applyStimulus(2'b10, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFFE,   "rem_m100_7", 1'b0);
      applyStimulus(2'b10, 32'd100,      32'hFFFFFFF9,   32'd2,          "rem_100_m7", 1'b0);
      applyStimulus(2'b00, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   "div_100_m7", 1'b0);
      applyStimulus(2'b01, 32'd5,        32'd0,          32'hFFFFFFFF,   "divu_5_0",   1'b0);
      applyStimulus(2'b00, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFF,   "div_m5_0",   1'b0);
      applyStimulus(2'b10, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFB,   "rem_m5_0",   1'b0);
      applyStimulus(2'b11, 32'd5,        32'd0,          32'd5,          "remu_5_0",   1'b0);
      applyStimulus(2'b00, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   "div_ovf",    1'b0);
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF,   32'h00000000,   "rem_ovf",    1'b0);
      applyStimulus(2'b01, 32'h80000000, 32'hFFFFFFFF,   32'h00000000,   "divu_ovf",   1'b0);

      applyStimulus(2'b01, 32'd100,      32'd7,          32'd14,         "hold_first", 1'b1);
      applyStimulus(2'b01, 32'd50,       32'd5,          32'd10,         "hold_second", 1'b0);

      abortTest(1'b1);
      applyStimulus(2'b01, 32'd9,        32'd3,          32'd3,          "after_rst",  1'b0);
      abortTest(1'b0);
      applyStimulus(2'b01, 32'd9,        32'd3,          32'd3,          "after_flush", 1'b0);

      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("queue_empty", W'(exp_res_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divider that executes RV32M DIV, DIVU, REM and REMU, the inverse of the DSP-based multiply path.
- Sits in the execute stage beside the ALU. It holds the pipeline through the same combinational insert_bubble stall convention that multiply uses.
- It produces one result per accepted request, at a fixed latency, using a restoring shift-subtract algorithm at one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration counter is $clog2(WIDTH) bits wide.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. It is sampled only in IDLE and may stay high while the instruction sits stalled in execute.
- flush  input  1  synchronous abort of any operation in flight.
- div_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WIDTH  left operand, latched when start is accepted.
- divisor  input  WIDTH  right operand, latched when start is accepted.
- result  output  WIDTH  quotient or remainder, registered. It is valid while done=1 and holds its value until the next acceptance.
- done  output  1  registered, one-cycle pulse marking the cycle in which result is consumed.
- insert_bubble  output  1  combinational stall request to the pipeline.

Behaviour:
- Reset: state=IDLE, result=0, done=0, counter=0, internal registers=0. insert_bubble=0 while rst=1.
- Reset or flush in mid-operation: the FSM returns to IDLE on that edge, done=0, and the partial result is discarded. rst has priority over flush, and flush has priority over start.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - When start=1, latch div_op, a flag sgn=(div_op==DIV or div_op==REM), |dividend| and |divisor| (magnitudes taken only when sgn=1 and the operand MSB is set).
  - Also latch neg_q = sgn & (dividend MSB ^ divisor MSB) & (divisor!=0), and neg_r = sgn & dividend MSB.
  - Also latch the special-case flags: dz=(divisor==0) and ovf=(sgn & dividend==0x80000000 & divisor==all-ones).
  - Then clear the remainder, set counter=0 and go to CALC.
- CALC:
  - Each cycle: shift {rem,quo} left by 1, with the dividend MSB entering rem. If the shifted rem >= the divisor magnitude, subtract it and set the quotient LSB to 1.
  - counter increments each cycle. At counter==WIDTH-1 go to FIX, after exactly WIDTH iterations.
  - start is ignored.
- FIX: result register is loaded as follows:
  - Divide-by-zero: DIV/DIVU give all-ones; REM/REMU give the original dividend.
  - Overflow: DIV gives 0x80000000; REM gives 0.
  - Otherwise: DIV/DIVU give quo, negated if neg_q; REM/REMU give rem, negated if neg_r.
  - Then go to DONE.
- DONE: done=1 for exactly this cycle. Always go to IDLE next, regardless of start, because the stalled instruction leaves execute in this cycle.
- insert_bubble = (state==IDLE & start & !rst & !flush) | state==CALC | state==FIX.
- Latency: with start accepted in cycle k, insert_bubble is high for cycles k..k+WIDTH+1 (34 cycles at WIDTH=32). done=1 and the result is valid in cycle k+WIDTH+2. The FSM is back in IDLE at k+WIDTH+3, where a new start is accepted.
- Special cases also run the full WIDTH iterations, so latency is identical for all inputs.
- Arithmetic: all internal datapaths are WIDTH bits wide, plus one extra bit on the compare/subtract. Negation is two's complement. The magnitude of 0x80000000 is 0x80000000 as unsigned.
- Operand changes after acceptance have no effect.

Test Plan:
- DIVU 100/7, start in cycle k: insert_bubble high for k..k+33, done=1 only at k+34, result=14. REMU on the same operands gives result=2.
- DIV -100 (0xFFFFFF9C) / 7 -> 0xFFFFFFF2 (-14). REM on the same operands -> 0xFFFFFFFE (-2). REM 100/-7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. DIV -5/0 -> 0xFFFFFFFF. REM -5/0 -> 0xFFFFFFFB. Each has the same 34-cycle bubble.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0. DIVU on the same operands -> 0.
- start held high through DONE: no second operation starts and done pulses once. A new start at k+35 is accepted, and its done arrives at k+69.
- rst (or flush) asserted at k+10: IDLE, done=0 and insert_bubble=0 from k+11 (result also 0 on rst). A fresh DIVU 9/3 then gives result=3 with normal latency.
